mult_div_unit: RTL

Parametrised multi-cycle multiply/divide unit for the processor datapath's HI/LO path. It executes signed and unsigned multiply (radix-2 Booth) and signed and unsigned divide (restoring) on WIDTH-bit operands. Results go to the HI/LO registers, and a start/busy/done handshake connects it to the control unit. It generalises the single-mode 32-bit multiplier with a mode select, a divide datapath, a reset, zero fast paths and explicit status outputs.

---
 rtl/mult_div_pkg.sv | 26 ++
 rtl/mult_div_booth_step.sv | 27 ++
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states
// and small op-decode helpers.
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op_sel);
        return op_sel[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op_sel);
        return ~op_sel[0];
    endfunction

endpackage

// File: rtl/mult_div_booth_step.sv
// One radix-2 Booth iteration: add/subtract the multiplicand into the upper half of P,
// then arithmetic-shift P right by one.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH+2:0] p_i,
    input  logic [WIDTH:0]     a_i,
    output logic [2*WIDTH+2:0] p_o
);

    logic [WIDTH+1:0] upper_ext;
    logic [WIDTH+1:0] a_ext;
    logic [WIDTH+1:0] sum;

    // The sum is kept one bit wider than the accumulator so the shift is exact.
    always_comb begin
        upper_ext = {p_i[2*WIDTH+2], p_i[2*WIDTH+2:WIDTH+2]};
        a_ext     = {a_i[WIDTH], a_i};
        unique case (p_i[1:0])
            2'b10:   sum = upper_ext - a_ext;
            2'b01:   sum = upper_ext + a_ext;
            default: sum = upper_ext;
        endcase
        p_o = {sum, p_i[WIDTH+1:1]};
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed/unsigned multiply (Booth) and divide (restoring) unit feeding
// the HI/LO registers through a start/busy/done handshake.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] outHI,
    output logic [WIDTH-1:0] outLO
);

    localparam int PW = 2*WIDTH + 3;
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic             is_div_q, fast_q, q_neg_q, r_neg_q;
    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] rem_q, quo_q, rem_d, quo_d;
    logic             busy_q, done_q, div_zero_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             in_div, in_signed, a_neg, b_neg, in_fast;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    always_comb begin
        in_div    = op_is_div(op);
        in_signed = op_is_signed(op);
        a_neg     = in_signed & inA[WIDTH-1];
        b_neg     = in_signed & inB[WIDTH-1];
        a_mag     = a_neg ? -inA : inA;
        b_mag     = b_neg ? -inB : inB;
        in_fast   = (inB == '0) | (~in_div & (inA == '0));
    end

    // Restoring divide step; a_q holds the zero-extended divisor magnitude.
    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_ge    = div_shift >= a_q;
    assign div_diff  = div_shift[WIDTH-1:0] - a_q[WIDTH-1:0];
    assign rem_d     = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign quo_d     = {quo_q[WIDTH-2:0], div_ge};

    booth_step #(.WIDTH(WIDTH)) u_booth (
        .p_i (p_q),
        .a_i (a_q),
        .p_o (p_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            is_div_q   <= 1'b0;
            fast_q     <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            cnt_q      <= '0;
            p_q        <= '0;
            a_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div_q   <= in_div;
                        fast_q     <= in_fast;
                        q_neg_q    <= a_neg ^ b_neg;
                        r_neg_q    <= a_neg;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        if (in_div) begin
                            a_q   <= {1'b0, b_mag};
                            quo_q <= a_mag;
                            rem_q <= '0;
                        end else begin
                            a_q <= {a_neg, inA};
                            p_q <= {{(WIDTH+1){1'b0}}, b_neg, inB, 1'b0};
                        end
                        state_q <= in_fast ? FINISH : RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (is_div_q) begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                    end else begin
                        p_q <= p_d;
                    end
                    if (cnt_q == (is_div_q ? DIV_LAST : MUL_LAST)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    if (fast_q) begin
                        // Divide-by-zero leaves HI/LO untouched; zero multiply clears them.
                        if (is_div_q) begin
                            div_zero_q <= 1'b1;
                        end else begin
                            hi_q <= '0;
                            lo_q <= '0;
                        end
                    end else if (is_div_q) begin
                        lo_q <= q_neg_q ? -quo_q : quo_q;
                        hi_q <= r_neg_q ? -rem_q : rem_q;
                    end else begin
                        hi_q <= p_q[2*WIDTH:WIDTH+1];
                        lo_q <= p_q[WIDTH:1];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign outHI    = hi_q;
    assign outLO    = lo_q;

endmodule
